pwm_timebase_controller: RTL
============================

// Module: pwm_timebase_controller
// PURPOSE
//  Sequences one or more pwm half-bridge blocks: owns the shared period counter, the
//  run/stop state machine and the runtime duty-cycle configuration. Drives tick_counter,
//  tick_count_highside/lowside and load_enable, so new settings reach pwm shadow regs
//  only at period start. Sits between the control loop (config source) and the pwm blocks.
// PARAMETERS
//  bitwidth        `BITWIDTH_PWM_COUNTER  counter/config width (all tick values)
//  period_default  100                    period (ticks) in use after reset, before any config
// PORTS
//  clock                input   1         single clock; all logic on posedge
//  reset                input   1         asynchronous, active-low (0 = reset)
//  enable               input   1         run request; level-sensitive
//  cfg_valid            input   1         config offered
//  cfg_ready            output  1         config slot free; transfer when valid&&ready
//  cfg_period           input   bitwidth  period in ticks (counter runs 0..period-1)
//  cfg_tick_highside    input   bitwidth  highside on-time, ticks
//  cfg_tick_lowside     input   bitwidth  lowside on-time, ticks
//  cfg_error            output  1         1-cycle pulse: transferred config rejected
//  tick_counter         output  bitwidth  shared counter to pwm blocks
//  tick_count_highside  output  bitwidth  to pwm blocks
//  tick_count_lowside   output  bitwidth  to pwm blocks
//  load_enable          output  1         to pwm blocks; high only during a tick_counter==0 cycle
//  running              output  1         1 in RUNNING/STOPPING
// BEHAVIOUR
//  Reset values: tick_counter=all-ones, tick_count_*=0, load_enable=0, cfg_ready=1,
//   cfg_error=0, running=0; state STOPPED; active period=period_default; staged cfg dropped.
//  STOPPED: tick_counter held all-ones (>= any shadow -> pwm holds both gates off).
//  States: STOPPED -enable=1-> RUNNING (next cycle counter=0, load_enable=1).
//   RUNNING -enable=0-> STOPPING; STOPPING -enable=1-> RUNNING (no counter disturbance);
//   STOPPING at last tick (period-1) -> STOPPED, counter all-ones next cycle.
//  Counter: RUNNING/STOPPING increments by 1; at period-1 wraps to 0. All outputs registered.
//  Validation on transfer: reject if cfg_period<2 or highside+lowside (bitwidth+1-bit sum)
//   > cfg_period. Rejected: cfg_error=1 next cycle, nothing staged, cfg_ready stays 1.
//  Accepted: staged, pending=1, cfg_ready=0 from next cycle. A new transfer cannot occur
//   while pending.
//  Commit: in the cycle counter==period-1 (running) or any STOPPED cycle with enable=1:
//   active period and tick_count_* take staged values, pending=0, load_enable=1 on next
//   (counter==0) cycle; cfg_ready=1 again that same cycle. No pending: load_enable=0,
//   except first period after start (always 1). Commit while stopped/enable=0: none.
//  Simultaneous: transfer in the commit cycle is staged, not committed (applies next period).
//  Reset mid-operation: immediate return to reset values, pending config discarded.
// CONFIGURATION
//  PWM_TIMEBASE_FAULT_EN defined: adds inputs fault, fault_clear and output fault_active.
//   fault=1 in any state -> next cycle FAULT: counter all-ones, load_enable=0, running=0,
//   fault_active=1, enable ignored; leave to STOPPED only on fault_clear=1 with fault=0.
//   Staged config kept. Not defined: no ports, no FAULT state; behaviour above unchanged.
// STRUCTURE
//  Shared header control/pwm.vh: BITWIDTH_PWM_COUNTER, state encodings
//   (STOPPED/RUNNING/STOPPING/FAULT), minimum period constant (2).
//  Sub-module pwm_config_stage: validation, staging regs, pending flag, cfg_ready/cfg_error.
//   Top keeps FSM, counter, commit strobe.
// TESTING (bitwidth=8, period_default=100)
//  Reset, cfg 10/4/5 then enable=1 -> counter 0..9 wraps, load_enable only 1st cycle, hs=4 ls=5.
//  Running p=10, cfg 10/2/5 at counter 3 -> cfg_ready=0 until commit; next counter=0 load_enable=1, hs=2.
//  cfg 10/6/5 and cfg 1/0/0 -> cfg_error 1-cycle pulse each; outputs and period unchanged.
//  enable=0 at counter 4 -> counts to 9, then 255, running=0; enable re-1 at counter 7 -> no stop.
//  reset=0 at counter 5 with pending cfg -> counter 255 immediately; after release cfg_ready=1.
//  FAULT_EN: fault at counter 3 -> counter 255, fault_active=1; enable ignored until fault_clear.

Source files
------------

// File: rtl/pwm_timebase_controller_pkg.sv
// Shared constants and state encoding for the PWM timebase controller and its config stage.
package pwm_timebase_controller_pkg;

  localparam int BITWIDTH_PWM_COUNTER = 8;
  localparam int MIN_PERIOD           = 2;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2,
    ST_FAULT    = 2'd3
  } tb_state_e;

endpackage

// File: rtl/pwm_timebase_controller_config_stage.sv
// Validates runtime PWM configuration, holds one staged setting until the timebase
// commits it at a period boundary, and drives the cfg_ready/cfg_error handshake.
module pwm_timebase_controller_config_stage
  import pwm_timebase_controller_pkg::*;
#(
  parameter int bitwidth = BITWIDTH_PWM_COUNTER
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [bitwidth-1:0] cfg_period,
  input  logic [bitwidth-1:0] cfg_tick_highside,
  input  logic [bitwidth-1:0] cfg_tick_lowside,
  output logic                cfg_error,
  input  logic                commit,
  output logic                pending,
  output logic [bitwidth-1:0] staged_period,
  output logic [bitwidth-1:0] staged_highside,
  output logic [bitwidth-1:0] staged_lowside
);

  localparam logic [bitwidth-1:0] MIN_P = bitwidth'(MIN_PERIOD);

  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [bitwidth-1:0] per_q, per_d;
  logic [bitwidth-1:0] hs_q, hs_d;
  logic [bitwidth-1:0] ls_q, ls_d;
  logic [bitwidth:0]   on_sum;
  logic                transfer;
  logic                reject;

  // Extra carry bit so two large on-times cannot wrap into an acceptable sum.
  assign on_sum   = {1'b0, cfg_tick_highside} + {1'b0, cfg_tick_lowside};
  assign transfer = cfg_valid && ready_q;
  assign reject   = (cfg_period < MIN_P) || (on_sum > {1'b0, cfg_period});

  always_comb begin
    ready_d = ready_q;
    error_d = 1'b0;
    per_d   = per_q;
    hs_d    = hs_q;
    ls_d    = ls_q;
    if (commit) begin
      ready_d = 1'b1;
    end
    if (transfer) begin
      if (reject) begin
        error_d = 1'b1;
      end else begin
        per_d   = cfg_period;
        hs_d    = cfg_tick_highside;
        ls_d    = cfg_tick_lowside;
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      error_q <= 1'b0;
      per_q   <= '0;
      hs_q    <= '0;
      ls_q    <= '0;
    end else begin
      ready_q <= ready_d;
      error_q <= error_d;
      per_q   <= per_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

  assign cfg_ready       = ready_q;
  assign cfg_error       = error_q;
  assign pending         = ~ready_q;
  assign staged_period   = per_q;
  assign staged_highside = hs_q;
  assign staged_lowside  = ls_q;

endmodule

// File: rtl/pwm_timebase_controller.sv
// Shared PWM period counter, run/stop sequencing and period-aligned config commit.
// Optional fault handling is enabled by defining PWM_TIMEBASE_FAULT_EN.
//   state       | meaning
//   ST_STOPPED  | counter parked at all-ones, gates held off
//   ST_RUNNING  | counting 0..period-1 and wrapping
//   ST_STOPPING | finishing the current period, then stop
//   ST_FAULT    | parked like STOPPED until fault_clear
module pwm_timebase_controller
  import pwm_timebase_controller_pkg::*;
#(
  parameter int bitwidth       = BITWIDTH_PWM_COUNTER,
  parameter int period_default = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
`ifdef PWM_TIMEBASE_FAULT_EN
  input  logic                fault,
  input  logic                fault_clear,
  output logic                fault_active,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [bitwidth-1:0] cfg_period,
  input  logic [bitwidth-1:0] cfg_tick_highside,
  input  logic [bitwidth-1:0] cfg_tick_lowside,
  output logic                cfg_error,
  output logic [bitwidth-1:0] tick_counter,
  output logic [bitwidth-1:0] tick_count_highside,
  output logic [bitwidth-1:0] tick_count_lowside,
  output logic                load_enable,
  output logic                running
);

  localparam logic [bitwidth-1:0] CNT_IDLE   = '1;
  localparam logic [bitwidth-1:0] CNT_ONE    = bitwidth'(1);
  localparam logic [bitwidth-1:0] PERIOD_RST = bitwidth'(period_default);

  tb_state_e           state_q, state_d;
  logic [bitwidth-1:0] cnt_q, cnt_d;
  logic [bitwidth-1:0] period_q, period_d;
  logic [bitwidth-1:0] hs_q, hs_d;
  logic [bitwidth-1:0] ls_q, ls_d;
  logic                load_q, load_d;
  logic                running_q, running_d;
  logic                commit;
  logic                pending;
  logic                wrap;
  logic [bitwidth-1:0] staged_period;
  logic [bitwidth-1:0] staged_highside;
  logic [bitwidth-1:0] staged_lowside;

  pwm_timebase_controller_config_stage #(.bitwidth(bitwidth)) u_config_stage (
    .clock             (clock),
    .reset             (reset),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_period        (cfg_period),
    .cfg_tick_highside (cfg_tick_highside),
    .cfg_tick_lowside  (cfg_tick_lowside),
    .cfg_error         (cfg_error),
    .commit            (commit),
    .pending           (pending),
    .staged_period     (staged_period),
    .staged_highside   (staged_highside),
    .staged_lowside    (staged_lowside)
  );

  assign wrap = (cnt_q == (period_q - CNT_ONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    commit   = 1'b0;
    period_d = period_q;
    hs_d     = hs_q;
    ls_d     = ls_q;
    case (state_q)
      ST_STOPPED: begin
        if (enable) begin
          state_d = ST_RUNNING;
          cnt_d   = '0;
          load_d  = 1'b1;
          commit  = pending;
        end
      end
      ST_RUNNING, ST_STOPPING: begin
        if (!wrap) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = enable ? ST_RUNNING : ST_STOPPING;
        end else if ((state_q == ST_STOPPING) && !enable) begin
          state_d = ST_STOPPED;
          cnt_d   = CNT_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = enable ? ST_RUNNING : ST_STOPPING;
          commit  = pending;
          load_d  = pending;
        end
      end
      ST_FAULT: begin
        cnt_d = CNT_IDLE;
`ifdef PWM_TIMEBASE_FAULT_EN
        if (fault_clear && !fault) state_d = ST_STOPPED;
`else
        state_d = ST_STOPPED;
`endif
      end
      default: begin
        state_d = ST_STOPPED;
        cnt_d   = CNT_IDLE;
      end
    endcase
`ifdef PWM_TIMEBASE_FAULT_EN
    if (fault) begin
      state_d = ST_FAULT;
      cnt_d   = CNT_IDLE;
      load_d  = 1'b0;
      commit  = 1'b0;
    end
`endif
    if (commit) begin
      period_d = staged_period;
      hs_d     = staged_highside;
      ls_d     = staged_lowside;
    end
  end

  assign running_d = (state_d == ST_RUNNING) || (state_d == ST_STOPPING);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOPPED;
      cnt_q     <= CNT_IDLE;
      period_q  <= PERIOD_RST;
      hs_q      <= '0;
      ls_q      <= '0;
      load_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      hs_q      <= hs_d;
      ls_q      <= ls_d;
      load_q    <= load_d;
      running_q <= running_d;
    end
  end

`ifdef PWM_TIMEBASE_FAULT_EN
  logic fault_active_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fault_active_q <= 1'b0;
    else        fault_active_q <= (state_d == ST_FAULT);
  end

  assign fault_active = fault_active_q;
`endif

  assign tick_counter        = cnt_q;
  assign tick_count_highside = hs_q;
  assign tick_count_lowside  = ls_q;
  assign load_enable         = load_q;
  assign running             = running_q;

endmodule
